apb2axi_axi_issuer: RTL

Consumer end of the bridge's request FIFO: pops one packed request entry at a time, issues it as a single-beat AXI4 write (AW+W, then B) or read (AR, then R), and pushes a packed completion entry into the completion FIFO. It is the AXI-side master engine between the request FIFO pop port and the completion FIFO push port. Only one transaction is outstanding at any time.

---
 rtl/apb2axi_pkg.sv | 49 ++++
 rtl/apb2axi_axi_issuer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge.
package apb2axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int REQ_TAG_W  = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Request FIFO entry, MSB first.
    typedef struct packed {
        logic                    is_write;
        logic [AXI_ADDR_W-1:0]   addr;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic [REQ_TAG_W-1:0]    tag;
    } req_entry_t;

    // Completion FIFO entry, MSB first.
    typedef struct packed {
        logic [REQ_TAG_W-1:0]  tag;
        logic                  is_write;
        logic [1:0]            resp;
        logic [AXI_DATA_W-1:0] rdata;
    } cpl_entry_t;

    localparam int REQ_W = $bits(req_entry_t);
    localparam int CPL_W = $bits(cpl_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_CPL
    } issuer_state_e;

    // AXI AxSIZE encoding for a full-width beat of the given byte count.
    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/apb2axi_axi_issuer.sv
// Single-outstanding AXI4 master: pops a request entry, issues one
// single-beat write or read, and pushes a completion entry.
module apb2axi_axi_issuer
    import apb2axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int ID_W   = AXI_ID_W,
    parameter int TAG_W  = REQ_TAG_W
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [1+ADDR_W+DATA_W+DATA_W/8+TAG_W-1:0] req_data,
    output logic                                   cpl_valid,
    input  logic                                   cpl_ready,
    output logic [TAG_W+1+2+DATA_W-1:0]            cpl_data,
    output logic                                   awvalid,
    input  logic                                   awready,
    output logic [ADDR_W-1:0]                      awaddr,
    output logic [ID_W-1:0]                        awid,
    output logic [7:0]                             awlen,
    output logic [2:0]                             awsize,
    output logic [1:0]                             awburst,
    output logic                                   wvalid,
    input  logic                                   wready,
    output logic [DATA_W-1:0]                      wdata,
    output logic [DATA_W/8-1:0]                    wstrb,
    output logic                                   wlast,
    input  logic                                   bvalid,
    output logic                                   bready,
    input  logic [ID_W-1:0]                        bid,
    input  logic [1:0]                             bresp,
    output logic                                   arvalid,
    input  logic                                   arready,
    output logic [ADDR_W-1:0]                      araddr,
    output logic [ID_W-1:0]                        arid,
    output logic [7:0]                             arlen,
    output logic [2:0]                             arsize,
    output logic [1:0]                             arburst,
    input  logic                                   rvalid,
    output logic                                   rready,
    input  logic [ID_W-1:0]                        rid,
    input  logic [DATA_W-1:0]                      rdata,
    input  logic [1:0]                             rresp,
    input  logic                                   rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W_L = 1 + ADDR_W + DATA_W + STRB_W + TAG_W;
    localparam logic [2:0] BEAT_SIZE = axi_size(STRB_W);

    issuer_state_e state_q, state_d;
    logic run_q;

    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic [ID_W-1:0] issued_id;
    logic req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, cpl_hs;

    // Request entry fields.
    logic              req_is_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic [TAG_W-1:0]  req_tag;

    assign req_is_write = req_data[REQ_W_L-1];
    assign req_addr     = req_data[REQ_W_L-2 -: ADDR_W];
    assign req_wdata    = req_data[TAG_W+STRB_W +: DATA_W];
    assign req_wstrb    = req_data[TAG_W +: STRB_W];
    assign req_tag      = req_data[0 +: TAG_W];

    // All handshake-facing valids/readys decode from registered state only;
    // run_q keeps req_ready low until the first edge after reset release.
    assign req_ready = run_q && (state_q == ST_IDLE);
    assign awvalid   = (state_q == ST_WR_ADDR_DATA) && !aw_done_q;
    assign wvalid    = (state_q == ST_WR_ADDR_DATA) && !w_done_q;
    assign bready    = (state_q == ST_WR_RESP);
    assign arvalid   = (state_q == ST_RD_ADDR);
    assign rready    = (state_q == ST_RD_DATA);
    assign cpl_valid = (state_q == ST_CPL);

    assign req_hs = req_valid && req_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign cpl_hs = cpl_valid && cpl_ready;

    assign issued_id = ID_W'(tag_q);

    assign awaddr  = addr_q;
    assign awid    = issued_id;
    assign awlen   = 8'd0;
    assign awsize  = BEAT_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign araddr  = addr_q;
    assign arid    = issued_id;
    assign arlen   = 8'd0;
    assign arsize  = BEAT_SIZE;
    assign arburst = AXI_BURST_INCR;

    assign cpl_data = {tag_q, is_write_q, resp_q, rdata_q};

    // Next-state and capture logic for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        tag_d      = tag_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    is_write_d = req_is_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wstrb_d    = req_wstrb;
                    tag_d      = req_tag;
                    resp_d     = AXI_RESP_OKAY;
                    rdata_d    = '0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = req_is_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                // Both channels done, possibly finishing in the same cycle.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    resp_d  = (bid != issued_id) ? AXI_RESP_SLVERR : bresp;
                    state_d = ST_CPL;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    resp_d  = ((rid != issued_id) || !rlast) ? AXI_RESP_SLVERR : rresp;
                    rdata_d = rdata;
                    state_d = ST_CPL;
                end
            end
            ST_CPL: begin
                if (cpl_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Captured request fields, response and progress flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            tag_q      <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            tag_q      <= tag_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule
